// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller: segment codes,
// anode idle pattern and FSM state encodings.
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'b111_1111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [0:0] SHOW  = 1'b0;
  localparam logic [0:0] BLANK = 1'b1;

  // Active-low hex glyphs, element 0 is the glyph for nibble 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b011_1000,  // F
    7'b011_0000,  // E
    7'b100_0010,  // d
    7'b011_0001,  // C
    7'b110_0000,  // b
    7'b000_1000,  // A
    7'b000_0100,  // 9
    7'b000_0000,  // 8
    7'b000_1111,  // 7
    7'b010_0000,  // 6
    7'b010_0100,  // 5
    7'b100_1100,  // 4
    7'b000_0110,  // 3
    7'b001_0010,  // 2
    7'b100_1111,  // 1
    7'b000_0001   // 0
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between user logic (master) and the scan controller (slave):
// data/load handshake in, board-pin drive and status pulses out.
interface seg7_scan_ctrl_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic        load_ack;
  logic        frame_done;
  logic [3:0]  AN;
  logic [6:0]  a_to_g;
  logic        dp;

  modport master (
    output data_in, dp_in, digit_en, load,
    input  load_ack, frame_done, AN, a_to_g, dp
  );

  modport slave (
    input  data_in, dp_in, digit_en, load,
    output load_ack, frame_done, AN, a_to_g, dp
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with blanking gaps and
// frame-aligned commit of new display data.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_ctrl_if.slave   bus
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [19:0]      pend_q, pend_d;      // {dp, data}
  logic             pflag_q, pflag_d;
  logic [19:0]      shadow_q, shadow_d;  // {dp, data}
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             ack_q, ack_d;
  logic             fd_q, fd_d;
  logic             wrap;
  logic [3:0]       cur_nibble;
  logic [3:0]       shadow_dp;
  logic [6:0]       cur_seg;

  assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];
  assign shadow_dp  = shadow_q[19:16];

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (state_q == SHOW) begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
        state_d = SHOW;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        wrap    = (idx_q == 2'd3);
      end
    end
  end

  // A load landing on the commit cycle bypasses the pending register.
  always_comb begin
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    fd_d     = wrap;
    if (bus.load) begin
      pend_d  = {bus.dp_in, bus.data_in};
      pflag_d = 1'b1;
    end
    if (wrap && (pflag_q || bus.load)) begin
      shadow_d = bus.load ? {bus.dp_in, bus.data_in} : pend_q;
      pflag_d  = 1'b0;
      ack_d    = 1'b1;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == SHOW) begin
      if (bus.digit_en[idx_q]) begin
        an_d = ~(4'b0001 << idx_q);
      end
      seg_d = cur_seg;
      dp_d  = ~shadow_dp[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SHOW;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      ack_q    <= ack_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.a_to_g     = seg_q;
  assign bus.dp         = dp_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_done = fd_q;

endmodule
